// File: rtl/dmem_dma_pkg.sv
// -----------------------------------------------------------------------------
// dmem_dma_pkg
// Shared types and constants for the dmem_dma word-copy initiator.
//   dma_state_t : controller state encoding (also visible on dbg_state)
//   WORD_BYTES  : byte stride between consecutive 32-bit words
// Optional feature macro used by the top: DMEM_DMA_CHECKSUM_EN
// -----------------------------------------------------------------------------
package dmem_dma_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        RD   = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } dma_state_t;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/dmem_dma_ctr.sv
// -----------------------------------------------------------------------------
// dmem_dma_ctr
// Source/destination word pointers and remaining-word counter.
// Ports:
//   clk, i_reset        clock, synchronous active-high reset (clears all)
//   i_load              load pointers and count from i_src/i_dst/i_len
//   i_step              advance both pointers one word, decrement count
//   i_src, i_dst        word-aligned start addresses to load
//   i_len               number of words to load
//   o_src_ptr/o_dst_ptr current read/write byte addresses
//   o_last              remaining count is exactly one
// Pointers wrap modulo 2^ADDR_W.
// -----------------------------------------------------------------------------
module dmem_dma_ctr
    import dmem_dma_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [ADDR_W-1:0] i_src,
    input  logic [ADDR_W-1:0] i_dst,
    input  logic [LEN_W-1:0]  i_len,
    output logic [ADDR_W-1:0] o_src_ptr,
    output logic [ADDR_W-1:0] o_dst_ptr,
    output logic              o_last
);

    logic [ADDR_W-1:0] r_src_ptr;
    logic [ADDR_W-1:0] r_dst_ptr;
    logic [LEN_W-1:0]  r_remaining;

    always_ff @(posedge clk) begin
        if (i_reset) begin
            r_src_ptr   <= '0;
            r_dst_ptr   <= '0;
            r_remaining <= '0;
        end else if (i_load) begin
            r_src_ptr   <= i_src;
            r_dst_ptr   <= i_dst;
            r_remaining <= i_len;
        end else if (i_step) begin
            r_src_ptr   <= r_src_ptr + ADDR_W'(WORD_BYTES);
            r_dst_ptr   <= r_dst_ptr + ADDR_W'(WORD_BYTES);
            r_remaining <= r_remaining - LEN_W'(1);
        end
    end

    assign o_src_ptr = r_src_ptr;
    assign o_dst_ptr = r_dst_ptr;
    assign o_last    = (r_remaining == LEN_W'(1));

endmodule

// File: rtl/dmem_dma.sv
// -----------------------------------------------------------------------------
// dmem_dma
// Bus initiator that copies len 32-bit words from byte address src to byte
// address dst over the data-memory port (combinational read, write on posedge).
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   start, src, dst, len transfer request (accepted only in IDLE)
//   busy, done           status: busy from accept through DONE, done pulse
//   bus_req, bus_gnt     port request / grant from the top-level arbiter
//   mem_we, mem_adr,
//   mem_wd, mem_rd       data-memory port
//   dbg_state            current controller state (dma_state_t encoding)
//   checksum             only with DMEM_DMA_CHECKSUM_EN: mod-2^32 sum of
//                        every word written in the current/last transfer
// Handshake: bus_req is held high in REQ/RD/WR; a cycle counts as a bus
// transfer only when bus_gnt is high in that same cycle. Without grant the
// controller freezes its state and outputs, and mem_we stays low.
// -----------------------------------------------------------------------------
module dmem_dma
    import dmem_dma_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd,
    output logic [2:0]        dbg_state
`ifdef DMEM_DMA_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);

    dma_state_t        r_state;
    logic [31:0]       r_data;
    logic              w_accept;
    logic              w_step;
    logic              w_last;
    logic              w_we;
    logic [ADDR_W-1:0] w_src_ptr;
    logic [ADDR_W-1:0] w_dst_ptr;
    logic [ADDR_W-1:0] w_src_aligned;
    logic [ADDR_W-1:0] w_dst_aligned;

    assign w_accept      = (r_state == IDLE) && start;
    assign w_step        = (r_state == WR) && bus_gnt;
    assign w_src_aligned = {src[ADDR_W-1:2], 2'b00};
    assign w_dst_aligned = {dst[ADDR_W-1:2], 2'b00};

    dmem_dma_ctr #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_ctr (
        .clk       (clk),
        .i_reset   (reset),
        .i_load    (w_accept),
        .i_step    (w_step),
        .i_src     (w_src_aligned),
        .i_dst     (w_dst_aligned),
        .i_len     (len),
        .o_src_ptr (w_src_ptr),
        .o_dst_ptr (w_dst_ptr),
        .o_last    (w_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= (len == '0) ? DONE : REQ;
                    end
                end
                REQ: begin
                    if (bus_gnt) begin
                        r_state <= RD;
                    end
                end
                RD: begin
                    if (bus_gnt) begin
                        r_data  <= mem_rd;
                        r_state <= WR;
                    end
                end
                WR: begin
                    if (bus_gnt) begin
                        r_state <= w_last ? DONE : RD;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Reset is qualified in so that a transfer aborted mid-WR never writes
    // in the cycle the abort is taken.
    assign w_we = (r_state == WR) && bus_gnt && !reset;

    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign bus_req   = (r_state == REQ) || (r_state == RD) || (r_state == WR);
    assign mem_we    = w_we;
    assign mem_adr   = (r_state == RD) ? w_src_ptr :
                       (r_state == WR) ? w_dst_ptr : '0;
    assign mem_wd    = (r_state == WR) ? r_data : '0;
    assign dbg_state = r_state;

`ifdef DMEM_DMA_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= '0;
        end else if (w_we) begin
            r_checksum <= r_checksum + r_data;
        end
    end

    assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_dmem_dma.sv
// -----------------------------------------------------------------------------
// tb_dmem_dma
// Directed bench for dmem_dma. A word-indexed memory model answers the
// combinational read port and commits writes on posedge. Each transfer is
// observed over a fixed window of cycles counted from the accept edge
// (cycle 1 = the cycle right after the accept edge); per-cycle outputs are
// logged and the tests compare them against hand-derived values.
// -----------------------------------------------------------------------------
module tb_dmem_dma;
    import dmem_dma_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] src;
    logic [31:0] dst;
    logic [9:0]  len;
    logic        busy;
    logic        done;
    logic        bus_req;
    logic        bus_gnt;
    logic        mem_we;
    logic [31:0] mem_adr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
    logic [2:0]  dbg_state;
`ifdef DMEM_DMA_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int errors = 0;
    int checks = 0;

    dmem_dma dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .src       (src),
        .dst       (dst),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .bus_req   (bus_req),
        .bus_gnt   (bus_gnt),
        .mem_we    (mem_we),
        .mem_adr   (mem_adr),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd),
        .dbg_state (dbg_state)
`ifdef DMEM_DMA_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    logic [31:0] dmem [0:1023];
    assign mem_rd = dmem[mem_adr[11:2]];
    always @(posedge clk) begin
        if (mem_we) dmem[mem_adr[11:2]] <= mem_wd;
    end

    // ---------------- window schedule and logs ----------------
    int gnt_off_lo = -1;
    int gnt_off_hi = -1;
    int rst_at     = -1;
    int restart_at = -1;

    logic        busy_l [64];
    logic        done_l [64];
    logic        req_l  [64];
    logic        we_l   [64];
    logic [31:0] adr_l  [64];
    logic [2:0]  st_l   [64];
    logic [31:0] cks_l  [64];

    int busy_cnt, done_cnt, req_cnt, we_cnt, first_done;

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) dmem[i] = 32'h0;
    endtask

    task automatic clear_sched();
        gnt_off_lo = -1;
        gnt_off_hi = -1;
        rst_at     = -1;
        restart_at = -1;
    endtask

    // Issue a request; returns at the sample point of cycle 1.
    task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [9:0] l);
        @(negedge clk);
        start = 1'b1;
        src   = s;
        dst   = d;
        len   = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Run n cycles from cycle 1, applying the schedule and logging outputs.
    task automatic run(input int n);
        for (int c = 1; c <= n; c++) begin
            bus_gnt = !(c >= gnt_off_lo && c <= gnt_off_hi);
            reset   = (c == rst_at);
            if (c == restart_at) begin
                start = 1'b1;
                src   = 32'h0;
                dst   = 32'h20;
                len   = 10'd5;
            end else begin
                start = 1'b0;
            end
            #1;
            busy_l[c] = busy;
            done_l[c] = done;
            req_l[c]  = bus_req;
            we_l[c]   = mem_we;
            adr_l[c]  = mem_adr;
            st_l[c]   = dbg_state;
`ifdef DMEM_DMA_CHECKSUM_EN
            cks_l[c]  = checksum;
`else
            cks_l[c]  = 32'h0;
`endif
            @(negedge clk);
        end
        bus_gnt = 1'b1;
        reset   = 1'b0;
        start   = 1'b0;
        busy_cnt = 0; done_cnt = 0; req_cnt = 0; we_cnt = 0; first_done = 0;
        for (int c = 1; c <= n; c++) begin
            if (busy_l[c]) busy_cnt++;
            if (req_l[c])  req_cnt++;
            if (we_l[c])   we_cnt++;
            if (done_l[c]) begin
                done_cnt++;
                if (first_done == 0) first_done = c;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; start = 1'b0; bus_gnt = 1'b1;
        src = 32'h0; dst = 32'h0; len = 10'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
        checks++; if (bus_req !== 1'b0)    begin errors++; $display("FAIL reset_req: got %0b expected 0", bus_req); end
        checks++; if (mem_we !== 1'b0)     begin errors++; $display("FAIL reset_we: got %0b expected 0", mem_we); end
        checks++; if (mem_adr !== 32'h0)   begin errors++; $display("FAIL reset_adr: got %0h expected 0", mem_adr); end
        checks++; if (mem_wd !== 32'h0)    begin errors++; $display("FAIL reset_wd: got %0h expected 0", mem_wd); end
        checks++; if (dbg_state !== 3'(IDLE)) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, 3'(IDLE)); end
    endtask

    task automatic test_basic_copy();
        logic [31:0] exp_w [4];
        exp_w[0] = 32'd11; exp_w[1] = 32'd22; exp_w[2] = 32'd33; exp_w[3] = 32'd44;
        clear_mem(); clear_sched();
        for (int i = 0; i < 4; i++) dmem[i] = exp_w[i];
        do_start(32'h0, 32'h100, 10'd4);
        run(20);
        for (int i = 0; i < 4; i++) begin
            checks++; if (dmem[64+i] !== exp_w[i]) begin errors++; $display("FAIL basic_word%0d: got %0d expected %0d", i, dmem[64+i], exp_w[i]); end
        end
        checks++; if (first_done !== 10) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 10", first_done); end
        checks++; if (busy_cnt !== 10)   begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 10", busy_cnt); end
        checks++; if (done_cnt !== 1)    begin errors++; $display("FAIL basic_done_pulses: got %0d expected 1", done_cnt); end
        checks++; if (we_cnt !== 4)      begin errors++; $display("FAIL basic_writes: got %0d expected 4", we_cnt); end
        checks++; if (req_cnt !== 9)     begin errors++; $display("FAIL basic_req_cycles: got %0d expected 9", req_cnt); end
        checks++; if (adr_l[2] !== 32'h0)   begin errors++; $display("FAIL basic_rd_adr: got %0h expected 0", adr_l[2]); end
        checks++; if (adr_l[3] !== 32'h100) begin errors++; $display("FAIL basic_wr_adr: got %0h expected 100", adr_l[3]); end
        checks++; if (adr_l[15] !== 32'h0)  begin errors++; $display("FAIL basic_idle_adr: got %0h expected 0", adr_l[15]); end
    endtask

    task automatic test_len_zero();
        clear_mem(); clear_sched();
        do_start(32'h40, 32'h80, 10'd0);
        run(6);
        checks++; if (first_done !== 1) begin errors++; $display("FAIL len0_done_cycle: got %0d expected 1", first_done); end
        checks++; if (done_cnt !== 1)   begin errors++; $display("FAIL len0_done_pulses: got %0d expected 1", done_cnt); end
        checks++; if (busy_cnt !== 1)   begin errors++; $display("FAIL len0_busy_cycles: got %0d expected 1", busy_cnt); end
        checks++; if (we_cnt !== 0)     begin errors++; $display("FAIL len0_writes: got %0d expected 0", we_cnt); end
        checks++; if (req_cnt !== 0)    begin errors++; $display("FAIL len0_req_cycles: got %0d expected 0", req_cnt); end
    endtask

    task automatic test_grant_loss();
        int we_nogrant;
        int hits_w2;
        int adr_bad;
        clear_mem(); clear_sched();
        for (int i = 0; i < 4; i++) dmem[i] = 32'hA000_0000 + 32'(i + 1);
        gnt_off_lo = 5; gnt_off_hi = 7;   // WR of word 2 is cycle 5
        do_start(32'h0, 32'h180, 10'd4);
        run(24);
        we_nogrant = 0; hits_w2 = 0; adr_bad = 0;
        for (int c = 5; c <= 7; c++) begin
            if (we_l[c]) we_nogrant++;
            if (adr_l[c] !== 32'h184) adr_bad++;
        end
        for (int c = 1; c <= 24; c++) if (we_l[c] && adr_l[c] == 32'h184) hits_w2++;
        checks++; if (we_nogrant !== 0) begin errors++; $display("FAIL gnt_we_without_grant: got %0d expected 0", we_nogrant); end
        checks++; if (adr_bad !== 0)    begin errors++; $display("FAIL gnt_adr_held: got %0d bad cycles expected 0", adr_bad); end
        checks++; if (hits_w2 !== 1)    begin errors++; $display("FAIL gnt_word2_writes: got %0d expected 1", hits_w2); end
        checks++; if (we_cnt !== 4)     begin errors++; $display("FAIL gnt_writes: got %0d expected 4", we_cnt); end
        checks++; if (first_done !== 13) begin errors++; $display("FAIL gnt_done_cycle: got %0d expected 13", first_done); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (dmem[96+i] !== 32'hA000_0000 + 32'(i + 1)) begin errors++; $display("FAIL gnt_word%0d: got %0h expected %0h", i, dmem[96+i], 32'hA000_0000 + 32'(i + 1)); end
        end
    endtask

    task automatic test_reset_mid();
        clear_mem(); clear_sched();
        for (int i = 0; i < 8; i++) begin
            dmem[16+i]  = 32'h5500_0000 + 32'(i);
            dmem[192+i] = 32'hDEAD_BEEF;
        end
        rst_at = 6;   // RD of word 3
        do_start(32'h40, 32'h300, 10'd8);
        run(20);
        checks++; if (st_l[7] !== 3'(IDLE)) begin errors++; $display("FAIL rstmid_state: got %0d expected %0d", st_l[7], 3'(IDLE)); end
        checks++; if (busy_l[7] !== 1'b0)   begin errors++; $display("FAIL rstmid_busy: got %0b expected 0", busy_l[7]); end
        checks++; if (done_cnt !== 0)       begin errors++; $display("FAIL rstmid_done: got %0d expected 0", done_cnt); end
        checks++; if (we_cnt !== 2)         begin errors++; $display("FAIL rstmid_writes: got %0d expected 2", we_cnt); end
        checks++; if (dmem[192] !== 32'h5500_0000) begin errors++; $display("FAIL rstmid_word0: got %0h expected 55000000", dmem[192]); end
        checks++; if (dmem[193] !== 32'h5500_0001) begin errors++; $display("FAIL rstmid_word1: got %0h expected 55000001", dmem[193]); end
        checks++; if (dmem[194] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rstmid_word2: got %0h expected deadbeef", dmem[194]); end
    endtask

    task automatic test_misaligned_and_ignore();
        clear_mem(); clear_sched();
        dmem[510] = 32'hCAFE_F00D;
        dmem[4]   = 32'h1234_5678;
        dmem[8]   = 32'h1234_5678;
        restart_at = 2;   // second request while busy
        do_start(32'h7F9, 32'h11, 10'd1);
        run(14);
        checks++; if (adr_l[2] !== 32'h7F8) begin errors++; $display("FAIL mis_rd_adr: got %0h expected 7f8", adr_l[2]); end
        checks++; if (adr_l[3] !== 32'h10)  begin errors++; $display("FAIL mis_wr_adr: got %0h expected 10", adr_l[3]); end
        checks++; if (dmem[4] !== 32'hCAFE_F00D) begin errors++; $display("FAIL mis_data: got %0h expected cafef00d", dmem[4]); end
        checks++; if (dmem[8] !== 32'h1234_5678) begin errors++; $display("FAIL ignore_dst: got %0h expected 12345678", dmem[8]); end
        checks++; if (first_done !== 4) begin errors++; $display("FAIL mis_done_cycle: got %0d expected 4", first_done); end
        checks++; if (busy_cnt !== 4)   begin errors++; $display("FAIL ignore_busy_cycles: got %0d expected 4", busy_cnt); end
        checks++; if (we_cnt !== 1)     begin errors++; $display("FAIL ignore_writes: got %0d expected 1", we_cnt); end
    endtask

    task automatic test_checksum();
`ifdef DMEM_DMA_CHECKSUM_EN
        clear_mem(); clear_sched();
        dmem[0] = 32'hFFFF_FFFF;
        dmem[1] = 32'h0000_0002;
        do_start(32'h0, 32'h200, 10'd2);
        run(10);
        checks++; if (first_done !== 6)      begin errors++; $display("FAIL cks_done_cycle: got %0d expected 6", first_done); end
        checks++; if (cks_l[6] !== 32'h1)    begin errors++; $display("FAIL cks_at_done: got %0h expected 1", cks_l[6]); end
        checks++; if (cks_l[9] !== 32'h1)    begin errors++; $display("FAIL cks_held: got %0h expected 1", cks_l[9]); end
`endif
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic_copy();
        test_len_zero();
        test_grant_loss();
        test_reset_mid();
        test_misaligned_and_ignore();
        test_checksum();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
